// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM states, BCD digit limits
// and the packed mm:ss field layout used by the seven-segment display path.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Largest legal value of a units digit and of the seconds-tens digit
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Packed BCD layout {minuteXX, minuteX, secondXX, secondX}
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // A value is loadable when every digit is BCD and the seconds stay below 60
  function automatic logic mmss_valid(input mmss_t v);
    return (v.min_tens <= DIGIT_MAX) && (v.min_ones <= DIGIT_MAX) &&
           (v.sec_tens <= TENS_MAX)  && (v.sec_ones <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_mmss_decrement.sv
// Combinational one-second decrement of a packed BCD mm:ss value, with zero
// detection on both the input and the decremented result.
module bcd_mmss_decrement
  import countdown_timer_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] result,
  output logic        value_zero,
  output logic        result_zero
);

  mmss_t cur;
  mmss_t nxt;

  assign cur        = value;
  assign value_zero = (value == 16'h0000);

  // Subtract one second, rippling the borrow from secondX up to minuteXX; 00:00 holds
  always_comb begin
    nxt = cur;
    if (!value_zero) begin
      if (cur.sec_ones != 4'd0) begin
        nxt.sec_ones = cur.sec_ones - 4'd1;
      end else begin
        nxt.sec_ones = DIGIT_MAX;
        if (cur.sec_tens != 4'd0) begin
          nxt.sec_tens = cur.sec_tens - 4'd1;
        end else begin
          nxt.sec_tens = TENS_MAX;
          if (cur.min_ones != 4'd0) begin
            nxt.min_ones = cur.min_ones - 4'd1;
          end else begin
            nxt.min_ones = DIGIT_MAX;
            nxt.min_tens = cur.min_tens - 4'd1;
          end
        end
      end
    end
  end

  assign result      = nxt;
  assign result_zero = (nxt == 16'h0000);

endmodule

// File: rtl/countdown_timer.sv
// Loadable BCD mm:ss countdown timer with pause/resume and expiry flags.
// A prescaler divides clk down to one decrement per TICK_CYCLES cycles.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] time_left,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse,
  output logic        load_err
);

  localparam int PW = $clog2(TICK_CYCLES);

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [15:0]     dec_value;
  logic            value_zero;
  logic            dec_zero;
  logic            load_ok;
  logic            tick;

  bcd_mmss_decrement u_dec (
    .value       (time_left),
    .result      (dec_value),
    .value_zero  (value_zero),
    .result_zero (dec_zero)
  );

  assign load_ok = mmss_valid(load_value);
  assign tick    = (state == RUN) && (prescaler == PW'(TICK_CYCLES - 1));

  // Timer FSM: load beats pause beats start; a rejected load only raises load_err
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      time_left    <= 16'h0000;
      prescaler    <= '0;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      load_err     <= 1'b0;
      if (load) begin
        if (load_ok) begin
          state     <= IDLE;
          time_left <= load_value;
          prescaler <= '0;
          running   <= 1'b0;
          expired   <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start && !pause) begin
              prescaler <= '0;
              if (value_zero) begin
                state        <= EXPIRED;
                expired      <= 1'b1;
                expire_pulse <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            if (tick) begin
              prescaler <= '0;
              time_left <= dec_value;
              if (dec_zero) begin
                state        <= EXPIRED;
                running      <= 1'b0;
                expired      <= 1'b1;
                expire_pulse <= 1'b1;
              end else if (pause) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
              if (pause) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by random
// stimulus, all compared against a seconds-based behavioural model.
module tb_countdown_timer;

  localparam int TICK = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXPIRED = 3;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] time_left;
  logic        running;
  logic        expired;
  logic        expire_pulse;
  logic        load_err;

  int vectors = 0;
  int miscompares = 0;

  int m_secs;
  int m_phase;
  int m_mode;
  bit m_pulse;
  bit m_err;

  countdown_timer #(.TICK_CYCLES(TICK)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .pause        (pause),
    .time_left    (time_left),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .load_err     (load_err)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] toBcd(input int secs);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int fromBcd(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit isValidBcd(input logic [15:0] v);
    return (v[15:12] < 10) && (v[11:8] < 10) && (v[7:4] < 6) && (v[3:0] < 10);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock of the reference model, expressed in whole seconds and a phase count
  task automatic modelStep(input bit r, input bit l, input logic [15:0] lv, input bit s, input bit p);
    bit tick;
    if (!r) begin
      m_secs = 0; m_phase = 0; m_mode = M_IDLE; m_pulse = 0; m_err = 0;
      return;
    end
    m_pulse = 0;
    m_err = 0;
    tick = (m_mode == M_RUN) && (m_phase == TICK - 1);
    if (l) begin
      if (isValidBcd(lv)) begin
        m_secs = fromBcd(lv); m_phase = 0; m_mode = M_IDLE;
      end else begin
        m_err = 1;
      end
    end else if (m_mode == M_RUN) begin
      m_phase = (m_phase + 1) % TICK;
      if (tick) m_secs = m_secs - 1;
      if (tick && m_secs == 0) begin
        m_mode = M_EXPIRED; m_pulse = 1;
      end else if (p) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_IDLE && s && !p) begin
      if (m_secs == 0) begin
        m_mode = M_EXPIRED; m_pulse = 1;
      end else begin
        m_mode = M_RUN; m_phase = 0;
      end
    end else if (m_mode == M_PAUSE && s && !p) begin
      m_mode = M_RUN;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare at the falling edge
  task automatic applyStimulus(input bit r, input bit l, input logic [15:0] lv, input bit s, input bit p);
    rst = r; load = l; load_value = lv; start = s; pause = p;
    @(posedge clk);
    modelStep(r, l, lv, s, p);
    @(negedge clk);
    checkOutput("time_left", time_left, toBcd(m_secs));
    checkOutput("running", 16'(running), 16'(m_mode == M_RUN));
    checkOutput("expired", 16'(expired), 16'(m_mode == M_EXPIRED));
    checkOutput("expire_pulse", 16'(expire_pulse), 16'(m_pulse));
    checkOutput("load_err", 16'(load_err), 16'(m_err));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 16'h0000, 0, 0);
  endtask

  // Main sequence: directed scenarios, then random traffic
  initial begin
    logic [15:0] lv;
    rst = 0; load = 0; load_value = 16'h0000; start = 0; pause = 0;
    m_secs = 0; m_phase = 0; m_mode = M_IDLE; m_pulse = 0; m_err = 0;

    applyStimulus(0, 0, 16'h0000, 0, 0);
    applyStimulus(0, 1, 16'h0123, 1, 0);
    checkOutput("reset_time", time_left, 16'h0000);
    checkOutput("reset_running", 16'(running), 16'h0000);

    // 01:02 counts down through the minute boundary
    applyStimulus(1, 1, 16'h0102, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    checkOutput("s1_running", 16'(running), 16'h0001);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1, 0, 16'h0000, 0, 0);
      if (k == 3) checkOutput("s1_e3", time_left, 16'h0102);
      if (k == 4) checkOutput("s1_e4", time_left, 16'h0101);
      if (k == 8) checkOutput("s1_e8", time_left, 16'h0100);
      if (k == 12) checkOutput("s1_e12", time_left, 16'h0059);
    end

    // 00:01 expires on the first tick; start held afterwards has no effect
    applyStimulus(1, 1, 16'h0001, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    idleCycles(3);
    checkOutput("s2_e3", time_left, 16'h0001);
    idleCycles(1);
    checkOutput("s2_zero", time_left, 16'h0000);
    checkOutput("s2_expired", 16'(expired), 16'h0001);
    checkOutput("s2_pulse", 16'(expire_pulse), 16'h0001);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    checkOutput("s2_pulse_clear", 16'(expire_pulse), 16'h0000);
    checkOutput("s2_still_expired", 16'(expired), 16'h0001);
    applyStimulus(1, 0, 16'h0000, 1, 1);
    applyStimulus(1, 0, 16'h0000, 1, 0);

    // 10:00 borrows across every digit
    applyStimulus(1, 1, 16'h1000, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1, 0, 16'h0000, 0, 0);
      if (k == 4) checkOutput("s3_t1", time_left, 16'h0959);
      if (k == 8) checkOutput("s3_t2", time_left, 16'h0958);
      if (k == 12) checkOutput("s3_t3", time_left, 16'h0957);
      if (k == 16) checkOutput("s3_t4", time_left, 16'h0956);
    end

    // Pause after two running cycles keeps the partial second
    applyStimulus(1, 1, 16'h0005, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'h0000, 0, 1);
    checkOutput("s4_paused", 16'(running), 16'h0000);
    idleCycles(10);
    checkOutput("s4_hold", time_left, 16'h0005);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("s4_r1", time_left, 16'h0005);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("s4_r2", time_left, 16'h0004);

    // Invalid load is rejected; valid load beats pause and start
    applyStimulus(1, 1, 16'h0160, 0, 0);
    checkOutput("s5_err", 16'(load_err), 16'h0001);
    checkOutput("s5_keep", time_left, 16'h0004);
    checkOutput("s5_keep_run", 16'(running), 16'h0001);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("s5_err_clear", 16'(load_err), 16'h0000);
    applyStimulus(1, 1, 16'h0005, 1, 1);
    checkOutput("s5_load_prio", time_left, 16'h0005);
    checkOutput("s5_idle", 16'(running), 16'h0000);

    // Mid-count reset, then tick coinciding with load
    applyStimulus(1, 1, 16'h0010, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    idleCycles(5);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkOutput("s6_rst_time", time_left, 16'h0000);
    checkOutput("s6_rst_run", 16'(running), 16'h0000);
    applyStimulus(1, 1, 16'h0030, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    idleCycles(3);
    applyStimulus(1, 1, 16'h0045, 0, 0);
    checkOutput("s6_tick_load", time_left, 16'h0045);
    checkOutput("s6_tick_load_idle", 16'(running), 16'h0000);

    // Random traffic biased toward short, valid presets so expiry is common
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) lv = toBcd($urandom_range(0, 20));
      else if (sel < 8) lv = 16'($urandom);
      else lv = toBcd($urandom_range(0, 5999));
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, lv,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
